// File: rtl/nonrestoring_divider_pkg.sv
// Shared definitions for the iterative non-restoring divider: FSM encoding and
// default datapath sizing.
package nonrestoring_divider_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/nonrestoring_divider_if.sv
// Request/response bundle for the divider: start and operands in, busy/done and
// results out.
interface nonrestoring_divider_if #(
  parameter int WIDTH = 32
);

  logic             i_start;
  logic             i_signed;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic             o_dbz;

  modport master (
    output i_start, i_signed, i_dividend, i_divisor,
    input  o_busy, o_done, o_quotient, o_remainder, o_dbz
  );

  modport slave (
    input  i_start, i_signed, i_dividend, i_divisor,
    output o_busy, o_done, o_quotient, o_remainder, o_dbz
  );

endinterface

// File: rtl/nonrestoring_divider_step.sv
// One non-restoring iteration: shift the partial remainder left by one dividend
// bit, add or subtract the divisor by the sign of P, emit one quotient bit.
module nonrestoring_divider_step #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH:0]   i_p,
  input  logic        [WIDTH-1:0] i_q,
  input  logic        [WIDTH-1:0] i_d,
  output logic signed [WIDTH:0]   o_p,
  output logic        [WIDTH-1:0] o_q
);

  logic             sub;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   operand;
  logic [WIDTH:0]   sum;

  // Add and subtract share one carry-chain adder: subtraction is ~D with carry-in 1.
  assign sub     = ~i_p[WIDTH];
  assign shifted = {i_p[WIDTH-1:0], i_q[WIDTH-1]};
  assign operand = sub ? ~{1'b0, i_d} : {1'b0, i_d};
  assign sum     = shifted + operand + {{WIDTH{1'b0}}, sub};

  assign o_p = signed'(sum);
  assign o_q = {i_q[WIDTH-2:0], ~sum[WIDTH]};

endmodule

// File: rtl/nonrestoring_divider.sv
// Iterative signed/unsigned non-restoring divider, one quotient bit per clock,
// truncating semantics, start/busy/done handshake.
module nonrestoring_divider
  import nonrestoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  nonrestoring_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  state_t                   state_q, state_d;
  logic        [CW-1:0]     cnt_q, cnt_d;
  logic signed [WIDTH:0]    p_q, p_d;
  logic        [WIDTH-1:0]  q_q, q_d;
  logic        [WIDTH-1:0]  d_q, d_d;
  logic                     mode_q, mode_d;
  logic                     sign_q_q, sign_q_d;
  logic                     sign_r_q, sign_r_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     dbz_q, dbz_d;
  logic        [WIDTH-1:0]  quot_q, quot_d;
  logic        [WIDTH-1:0]  rem_q, rem_d;

  logic signed [WIDTH:0]    step_p;
  logic        [WIDTH-1:0]  step_q;
  logic        [WIDTH-1:0]  p_fix;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Unsigned magnitude; the most negative value maps to 2^(W-1) naturally.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    return cond_neg(v, is_signed & v[WIDTH-1]);
  endfunction

  nonrestoring_divider_step #(.WIDTH(WIDTH)) u_step (
    .i_p (p_q),
    .i_q (q_q),
    .i_d (d_q),
    .o_p (step_p),
    .o_q (step_q)
  );

  assign p_fix = p_q[WIDTH] ? (p_q[WIDTH-1:0] + d_q) : p_q[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    q_d      = q_q;
    d_d      = d_q;
    mode_d   = mode_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    quot_d   = quot_q;
    rem_d    = rem_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // Raw operands park in Q/D until PREP converts them to magnitudes.
        if (bus.i_start) begin
          state_d = S_PREP;
          q_d     = bus.i_dividend;
          d_d     = bus.i_divisor;
          mode_d  = bus.i_signed;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        sign_q_d = mode_q & (q_q[WIDTH-1] ^ d_q[WIDTH-1]);
        sign_r_d = mode_q & q_q[WIDTH-1];
        q_d      = magnitude(q_q, mode_q);
        d_d      = magnitude(d_q, mode_q);
        p_d      = '0;
        cnt_d    = '0;
        if (d_q == '0) begin
          state_d = S_DONE;
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        p_d   = step_p;
        q_d   = step_q;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        p_d     = signed'({1'b0, p_fix});
        quot_d  = cond_neg(q_q, sign_q_q);
        rem_d   = cond_neg(p_fix, sign_r_q);
        dbz_d   = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      mode_q   <= 1'b0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
      quot_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      q_q      <= q_d;
      d_q      <= d_d;
      mode_q   <= mode_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_dbz       = dbz_q;
  assign bus.o_quotient  = quot_q;
  assign bus.o_remainder = rem_q;

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Self-checking bench for nonrestoring_divider: directed corner cases plus random
// operands against a truncating-division reference model.
module tb_nonrestoring_divider;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  nonrestoring_divider_if #(.WIDTH(W)) bus ();

  nonrestoring_divider #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic void ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (!sg) begin
      q = a / b; r = a % b; z = 1'b0;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // Launches one request and counts edges after the accepting edge until o_done.
  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int edges, output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z);
    bus.i_start    = 1'b1;
    bus.i_signed   = sg;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    edges = 0;
    while (!bus.o_done && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    q = bus.o_quotient;
    r = bus.o_remainder;
    z = bus.o_dbz;
  endtask

  task automatic check_op(input string name, input logic sg, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input int elat);
    int e; logic [W-1:0] q, r; logic z;
    run_op(sg, a, b, e, q, r, z);
    total_cnt++;
    if (e !== elat) $display("FAIL %s latency: got %0d want %0d", name, e, elat);
    else pass_cnt++;
    total_cnt++;
    if (q !== eq) $display("FAIL %s quotient: got %h want %h", name, q, eq);
    else pass_cnt++;
    total_cnt++;
    if (r !== er) $display("FAIL %s remainder: got %h want %h", name, r, er);
    else pass_cnt++;
    total_cnt++;
    if (z !== ez) $display("FAIL %s dbz: got %b want %b", name, z, ez);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({bus.o_busy, bus.o_done, bus.o_dbz, bus.o_quotient, bus.o_remainder} !== '0)
      $display("FAIL reset_outputs: busy=%b done=%b dbz=%b q=%h r=%h want all zero",
               bus.o_busy, bus.o_done, bus.o_dbz, bus.o_quotient, bus.o_remainder);
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    check_op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 34);
    check_op("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 34);
    check_op("s7_-2",    1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 34);
    check_op("s_ovf",    1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 34);
    check_op("u_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 34);
    check_op("u_dbz",    1'b0, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1, 1);
    check_op("s_dbz",    1'b1, 32'h1234,       32'd0,          32'hFFFFFFFF,   32'h1234,       1'b1, 1);
  endtask

  task automatic test_busy_ignore();
    int e; logic [W-1:0] q, r; logic z;
    bus.i_start = 1'b1; bus.i_signed = 1'b0;
    bus.i_dividend = 32'd1000; bus.i_divisor = 32'd3;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    total_cnt++;
    if (bus.o_busy !== 1'b1) $display("FAIL busy_after_accept: got %b want 1", bus.o_busy);
    else pass_cnt++;
    e = 0;
    repeat (9) begin @(posedge clk); #1; e++; end
    bus.i_start = 1'b1; bus.i_dividend = 32'd77; bus.i_divisor = 32'd0;
    @(posedge clk); #1; e++;
    bus.i_start = 1'b0;
    while (!bus.o_done && e < 100) begin @(posedge clk); #1; e++; end
    q = bus.o_quotient; r = bus.o_remainder; z = bus.o_dbz;
    total_cnt++;
    if (e !== 34 || q !== 32'd333 || r !== 32'd1 || z !== 1'b0)
      $display("FAIL busy_ignore: lat=%0d q=%0d r=%0d dbz=%b want 34/333/1/0", e, q, r, z);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0)
      $display("FAIL idle_after_done: busy=%b done=%b want 0/0", bus.o_busy, bus.o_done);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int e; logic [W-1:0] q, r; logic z;
    run_op(1'b0, 32'd200, 32'd9, e, q, r, z);
    total_cnt++;
    if (q !== 32'd22 || r !== 32'd2) $display("FAIL b2b_first: q=%0d r=%0d want 22/2", q, r);
    else pass_cnt++;
    // Still in the DONE cycle: hold start for the second request.
    run_op(1'b1, 32'hFFFFFF9C, 32'd7, e, q, r, z);
    total_cnt++;
    if (e !== 34 || q !== 32'hFFFFFFF2 || r !== 32'hFFFFFFFE)
      $display("FAIL b2b_second: lat=%0d q=%h r=%h want 34/fffffff2/fffffffe", e, q, r);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    bit saw_done;
    bus.i_start = 1'b1; bus.i_signed = 1'b0;
    bus.i_dividend = 32'd12345; bus.i_divisor = 32'd11;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    total_cnt++;
    if ({bus.o_busy, bus.o_done, bus.o_dbz, bus.o_quotient, bus.o_remainder} !== '0)
      $display("FAIL reset_mid_op: busy=%b done=%b dbz=%b q=%h r=%h want all zero",
               bus.o_busy, bus.o_done, bus.o_dbz, bus.o_quotient, bus.o_remainder);
    else pass_cnt++;
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.o_done || bus.o_busy) saw_done = 1'b1;
    end
    total_cnt++;
    if (saw_done) $display("FAIL abort_no_done: got activity after reset want none");
    else pass_cnt++;
    check_op("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, eq, er; logic sg, ez; int sel;
    for (int i = 0; i < 40; i++) begin
      sg  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      a   = $urandom;
      if (sel == 9) a = 32'h80000000;
      if (sel == 0) b = '0;
      else if (sel < 4) begin
        b = W'($urandom_range(1, 15));
        if (sel == 3) b = -b;
      end else b = $urandom;
      ref_div(sg, a, b, eq, er, ez);
      check_op($sformatf("rand%0d", i), sg, a, b, eq, er, ez, (b == 0) ? 1 : 34);
    end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_signed = 1'b0;
    bus.i_dividend = '0; bus.i_divisor = '0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
